rotate_sweep_sequencer: RTL and testbench

//   Upstream driver for the combinational circular shifter (circular_shifter_8 family).

---
 rtl/rotate_sweep_sequencer_if.sv | 36 +++
 rtl/rotate_sweep_sequencer.sv | 84 ++++++++
 tb/tb_rotate_sweep_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/rotate_sweep_sequencer_if.sv
// Command, shifter-loop and result signals of the rotate sweep sequencer.
// The slave modport is the sequencer; the master modport drives it.
interface rotate_sweep_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_data;
    logic [SHW-1:0]   cmd_start;
    logic [SHW-1:0]   cmd_step;
    logic [SHW:0]     cmd_count;
    logic [WIDTH-1:0] sh_in;
    logic [SHW-1:0]   sh_amt;
    logic [WIDTH-1:0] sh_result;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic [SHW-1:0]   res_amt;
    logic             res_last;
    logic             busy;

    modport slave (
        input  cmd_valid, cmd_data, cmd_start, cmd_step, cmd_count,
        input  sh_result, res_ready,
        output cmd_ready, sh_in, sh_amt,
        output res_valid, res_data, res_amt, res_last, busy
    );

    modport master (
        output cmd_valid, cmd_data, cmd_start, cmd_step, cmd_count,
        output sh_result, res_ready,
        input  cmd_ready, sh_in, sh_amt,
        input  res_valid, res_data, res_amt, res_last, busy
    );
endinterface

// File: rtl/rotate_sweep_sequencer.sv
// Drives a combinational circular shifter through a sweep of shift amounts
// and streams each captured result out over valid/ready.
module rotate_sweep_sequencer #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    rotate_sweep_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_OUT     = 2'd2
    } state_t;

    state_t           r_state;
    logic [SHW-1:0]   r_step;
    logic [SHW:0]     r_remaining;
    logic [WIDTH-1:0] r_sh_in;
    logic [SHW-1:0]   r_sh_amt;
    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_data;
    logic [SHW-1:0]   r_res_amt;
    logic             r_res_last;

    assign bus.cmd_ready = (r_state == S_IDLE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.sh_in     = r_sh_in;
    assign bus.sh_amt    = r_sh_amt;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_amt   = r_res_amt;
    assign bus.res_last  = r_res_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_step      <= '0;
            r_remaining <= '0;
            r_sh_in     <= '0;
            r_sh_amt    <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_amt   <= '0;
            r_res_last  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_sh_in     <= bus.cmd_data;
                        r_sh_amt    <= bus.cmd_start;
                        r_step      <= bus.cmd_step;
                        r_remaining <= bus.cmd_count;
                        // A zero-length sweep is consumed without leaving IDLE.
                        if (bus.cmd_count != '0)
                            r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    r_res_data  <= bus.sh_result;
                    r_res_amt   <= r_sh_amt;
                    r_res_last  <= (r_remaining == (SHW+1)'(1));
                    r_res_valid <= 1'b1;
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_remaining <= r_remaining - (SHW+1)'(1);
                        if (r_res_last) begin
                            r_state <= S_IDLE;
                        end else begin
                            // Amount advances only here, giving the shifter a full settle cycle.
                            r_sh_amt <= r_sh_amt + r_step;
                            r_state  <= S_CAPTURE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rotate_sweep_sequencer.sv
// Closed-loop bench: a left-rotate model stands in for the shifter and a
// sweep model predicts every result, amount, last flag and latency.
module tb_rotate_sweep_sequencer;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rotate_sweep_sequencer_if #(.WIDTH(8), .SHW(3)) bus ();

    rotate_sweep_sequencer #(.WIDTH(8), .SHW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [7:0] rotl(input logic [7:0] d, input logic [2:0] a);
        logic [15:0] t;
        t = {d, d} << a;
        return t[15:8];
    endfunction

    assign bus.sh_result = rotl(bus.sh_in, bus.sh_amt);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        chk({tag, "_busy"},      32'(bus.busy),      32'd0);
        chk({tag, "_sh_in"},     32'(bus.sh_in),     32'd0);
        chk({tag, "_sh_amt"},    32'(bus.sh_amt),    32'd0);
        chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
        chk({tag, "_res_data"},  32'(bus.res_data),  32'd0);
        chk({tag, "_res_amt"},   32'(bus.res_amt),   32'd0);
        chk({tag, "_res_last"},  32'(bus.res_last),  32'd0);
    endtask

    // One command, checked result by result against the sweep rules.
    task automatic run(input logic [7:0] d, input logic [2:0] st,
                       input logic [2:0] sp, input logic [3:0] cnt,
                       input int stall_idx, input int stall_len,
                       input bit poke);
        logic [2:0] amt;
        int waited;
        @(negedge clk);
        chk("acc_ready", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = d;
        bus.cmd_start = st;
        bus.cmd_step  = sp;
        bus.cmd_count = cnt;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        if (cnt == 0) begin
            chk("zero_ready", 32'(bus.cmd_ready), 32'd1);
            chk("zero_busy",  32'(bus.busy),      32'd0);
            repeat (3) begin
                @(negedge clk);
                chk("zero_valid", 32'(bus.res_valid), 32'd0);
            end
            return;
        end
        amt = st;
        for (int k = 0; k < int'(cnt); k++) begin
            waited = 1;
            while (!bus.res_valid && waited < 8) begin
                @(negedge clk);
                waited++;
            end
            chk("latency",  32'(waited),        32'd2);
            chk("res_data", 32'(bus.res_data),  32'(rotl(d, amt)));
            chk("res_amt",  32'(bus.res_amt),   32'(amt));
            chk("res_last", 32'(bus.res_last),  32'(k == int'(cnt) - 1));
            chk("sh_in",    32'(bus.sh_in),     32'(d));
            chk("busy",     32'(bus.busy),      32'd1);
            if (poke && k == 0) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_data  = ~d;
                bus.cmd_count = 4'd1;
                chk("poke_ready", 32'(bus.cmd_ready), 32'd0);
            end
            if (k == stall_idx) begin
                bus.res_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    bus.cmd_valid = 1'b0;
                    chk("stall_valid",  32'(bus.res_valid), 32'd1);
                    chk("stall_data",   32'(bus.res_data),  32'(rotl(d, amt)));
                    chk("stall_amt",    32'(bus.res_amt),   32'(amt));
                    chk("stall_sh_amt", 32'(bus.sh_amt),    32'(amt));
                end
            end
            bus.res_ready = 1'b1;
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            amt = amt + sp;
        end
        chk("end_ready", 32'(bus.cmd_ready), 32'd1);
        chk("end_busy",  32'(bus.busy),      32'd0);
        chk("end_valid", 32'(bus.res_valid), 32'd0);
        chk("end_sh_in", 32'(bus.sh_in),     32'(d));
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
        bus.cmd_start = '0;
        bus.cmd_step  = '0;
        bus.cmd_count = '0;
        bus.res_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle_outputs("post_rst");

        run(8'haf, 3'd0, 3'd1, 4'd5, -1, 0, 1'b0);
        run(8'haf, 3'd6, 3'd1, 4'd3, -1, 0, 1'b0);
        run(8'haf, 3'd0, 3'd1, 4'd5, 1, 4, 1'b0);
        run(8'h55, 3'd2, 3'd3, 4'd0, -1, 0, 1'b0);
        run(8'h3c, 3'd1, 3'd2, 4'd4, -1, 0, 1'b1);
        run(8'h81, 3'd1, 3'd0, 4'd3, -1, 0, 1'b0);
        run(8'h96, 3'd5, 3'd3, 4'd15, 7, 2, 1'b0);

        for (int i = 0; i < 24; i++) begin
            logic [3:0] c;
            c = 4'($urandom_range(0, 15));
            run(8'($urandom), 3'($urandom), 3'($urandom), c,
                int'($urandom_range(0, 15)), int'($urandom_range(1, 4)),
                1'($urandom));
        end

        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 8'h5a;
        bus.cmd_start = 3'd3;
        bus.cmd_step  = 3'd1;
        bus.cmd_count = 4'd8;
        bus.res_ready = 1'b0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("mid_valid", 32'(bus.res_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_idle_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        bus.res_ready = 1'b1;
        @(negedge clk);
        chk_idle_outputs("after_async");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
